bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter_pkg.sv | 9 +
 rtl/parameters.sv | 11 +
 rtl/types.sv | 31 +++
 rtl/bank_arbiter_if.sv | 39 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/bank_arbiter.sv | 154 +++++++++++++++
 tb/tb_bank_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/bank_arbiter_pkg.sv
// Block-local helpers for the bank arbiter.
//   rr_next  round-robin pointer successor with wrap at n-1 -> 0
package bank_arbiter_pkg;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage : bank_arbiter_pkg

// File: rtl/parameters.sv
// Shared bank/mesh sizing constants.
//   MESH_DIMENSION  extent of the mesh along each axis
//   NODES_PER_BANK  node ports behind one bank arbiter
//   BANK_IDX_W      width of a node index inside a bank
package parameters;

   localparam int unsigned MESH_DIMENSION = 8;
   localparam int unsigned NODES_PER_BANK = 4;
   localparam int unsigned BANK_IDX_W     = (NODES_PER_BANK > 1) ? $clog2(NODES_PER_BANK) : 1;

endpackage : parameters

// File: rtl/types.sv
// Shared packet types for the mesh fabric.
//   ctrl_t   packet control encoding
//   coord_t  x/y/z destination coordinate
//   pkt_t    full packet payload (ctrl, addr, data)
package types;

   import parameters::*;

   localparam int unsigned COORD_W = $clog2(MESH_DIMENSION);
   localparam int unsigned DATA_W  = 16;

   typedef enum logic [1:0] {
      CTRL_NOP  = 2'd0,
      CTRL_SUM  = 2'd1,
      CTRL_DONE = 2'd2,
      CTRL_DATA = 2'd3
   } ctrl_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] z;
   } coord_t;

   typedef struct packed {
      ctrl_t             ctrl;
      coord_t            addr;
      logic [DATA_W-1:0] data;
   } pkt_t;

endpackage : types

// File: rtl/bank_arbiter_if.sv
// Mesh-side and node-side handshake bundle of one bank.
//   slave  : seen from the bank arbiter
//   master : seen from the environment (mesh router + nodes)
interface bank_arbiter_if #(
   parameter int unsigned N_NODES = parameters::NODES_PER_BANK
);
   import types::*;

   // mesh -> bank -> node
   logic               mesh_valid_in;
   logic               mesh_ready_in;
   pkt_t               mesh_in_pkt;
   logic [N_NODES-1:0] node_valid_in;
   logic [N_NODES-1:0] node_ready_in;
   pkt_t               node_in_pkt;

   // node -> bank -> mesh
   logic [N_NODES-1:0] node_valid_out;
   logic [N_NODES-1:0] node_ready_out;
   pkt_t               node_out_pkt [N_NODES];
   logic               mesh_valid_out;
   logic               mesh_ready_out;
   pkt_t               mesh_out_pkt;

   modport slave (
      input  mesh_valid_in, mesh_in_pkt, node_ready_in,
      input  node_valid_out, node_out_pkt, mesh_ready_out,
      output mesh_ready_in, node_valid_in, node_in_pkt,
      output node_ready_out, mesh_valid_out, mesh_out_pkt
   );

   modport master (
      output mesh_valid_in, mesh_in_pkt, node_ready_in,
      output node_valid_out, node_out_pkt, mesh_ready_out,
      input  mesh_ready_in, node_valid_in, node_in_pkt,
      input  node_ready_out, mesh_valid_out, mesh_out_pkt
   );

endinterface : bank_arbiter_if

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i  request vector
//   ptr_i  index where the search starts (highest priority)
//   gnt_o  one-hot grant, zero when no request
//   idx_o  winner index
//   any_o  at least one request present
module rr_arbiter #(
   parameter  int unsigned N = 4,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   // Walk ptr, ptr+1, ... wrapping modulo N; first requester wins.
   always_comb begin : search
      int unsigned j;
      logic [W-1:0] jw;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 32'd0;
      jw    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr_i) + k;
         if (j >= N) j = j - N;
         jw = W'(j);
         if (!any_o && req_i[jw]) begin
            any_o     = 1'b1;
            gnt_o[jw] = 1'b1;
            idx_o     = jw;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/bank_arbiter.sv
// Bank arbiter: one-entry ingress buffer routing mesh packets to the node
// selected by addr.z, and one-entry egress buffer fed by a round-robin
// arbiter over the node egress ports.
//   clk, rst  clock, synchronous active-high reset
//   bus       bank_arbiter_if.slave (mesh/node handshakes and packets)
//   bad_addr  sticky flag: an ingress packet addressed z >= N_NODES
// Optional feature: define BANK_ARB_DONE_PRIORITY_EN to let CTRL_DONE
// requesters (lowest index first) pre-empt round-robin order without
// moving the pointer.
module bank_arbiter
   import types::*;
   import bank_arbiter_pkg::*;
#(
   parameter int unsigned N_NODES = parameters::NODES_PER_BANK
) (
   input  logic          clk,
   input  logic          rst,
   bank_arbiter_if.slave bus,
   output logic          bad_addr
);

   localparam int unsigned IDX_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;

   // ---------------- ingress ----------------
   pkt_t               ibuf_q, ibuf_d;
   logic               ibuf_valid_q, ibuf_valid_d;
   logic               bad_addr_q, bad_addr_d;
   logic               ibuf_hit, sel_ready, ibuf_drain, mesh_ready_c, mesh_accept;
   logic [N_NODES-1:0] node_valid_in_c;

   // Decode destination node; a miss means z is outside this bank.
   always_comb begin : ingress_decode
      ibuf_hit        = 1'b0;
      sel_ready       = 1'b0;
      node_valid_in_c = '0;
      for (int unsigned i = 0; i < N_NODES; i++) begin
         if (32'(ibuf_q.addr.z) == i) begin
            ibuf_hit           = 1'b1;
            sel_ready          = bus.node_ready_in[i];
            node_valid_in_c[i] = ibuf_valid_q;
         end
      end
   end

   // Misaddressed packets drain unconditionally so they never block the bank.
   assign ibuf_drain   = ibuf_valid_q && (!ibuf_hit || sel_ready);
   assign mesh_ready_c = !ibuf_valid_q || ibuf_drain;
   assign mesh_accept  = bus.mesh_valid_in && mesh_ready_c;

   always_comb begin : ingress_next
      ibuf_d       = ibuf_q;
      ibuf_valid_d = ibuf_valid_q;
      bad_addr_d   = bad_addr_q;
      if (ibuf_drain) ibuf_valid_d = 1'b0;
      if (mesh_accept) begin
         ibuf_d       = bus.mesh_in_pkt;
         ibuf_valid_d = 1'b1;
      end
      if (ibuf_valid_q && !ibuf_hit) bad_addr_d = 1'b1;
   end

   // ---------------- egress ----------------
   pkt_t               obuf_q, obuf_d;
   logic               obuf_valid_q, obuf_valid_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_NODES-1:0] rr_gnt, win_onehot;
   logic [IDX_W-1:0]   rr_idx, winner;
   logic               rr_any, adv_ptr, obuf_drain, can_grant, grant;

   rr_arbiter #(.N(N_NODES)) u_rr (
      .req_i (bus.node_valid_out),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt),
      .idx_o (rr_idx),
      .any_o (rr_any)
   );

`ifdef BANK_ARB_DONE_PRIORITY_EN
   logic               done_any;
   logic [IDX_W-1:0]   done_idx;
   logic [N_NODES-1:0] done_gnt;

   // Lowest-index requester carrying CTRL_DONE.
   always_comb begin : done_pick
      done_any = 1'b0;
      done_idx = '0;
      done_gnt = '0;
      for (int unsigned i = 0; i < N_NODES; i++) begin
         if (!done_any && bus.node_valid_out[i] && bus.node_out_pkt[i].ctrl == CTRL_DONE) begin
            done_any    = 1'b1;
            done_idx    = IDX_W'(i);
            done_gnt[i] = 1'b1;
         end
      end
   end

   // A DONE win leaves the round-robin pointer where it was.
   always_comb begin : winner_pick
      winner     = done_any ? done_idx : rr_idx;
      win_onehot = done_any ? done_gnt : rr_gnt;
      adv_ptr    = !done_any;
   end
`else
   always_comb begin : winner_pick
      winner     = rr_idx;
      win_onehot = rr_gnt;
      adv_ptr    = 1'b1;
   end
`endif

   assign obuf_drain = obuf_valid_q && bus.mesh_ready_out;
   assign can_grant  = !obuf_valid_q || obuf_drain;
   assign grant      = !rst && can_grant && rr_any;

   always_comb begin : egress_next
      obuf_d       = obuf_q;
      obuf_valid_d = obuf_valid_q;
      rr_ptr_d     = rr_ptr_q;
      if (obuf_drain) obuf_valid_d = 1'b0;
      if (grant) begin
         obuf_d       = bus.node_out_pkt[winner];
         obuf_valid_d = 1'b1;
         if (adv_ptr) rr_ptr_d = IDX_W'(rr_next(32'(winner), N_NODES));
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge clk) begin : state_regs
      if (rst) begin
         ibuf_q       <= '0;
         ibuf_valid_q <= 1'b0;
         bad_addr_q   <= 1'b0;
         obuf_q       <= '0;
         obuf_valid_q <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         ibuf_q       <= ibuf_d;
         ibuf_valid_q <= ibuf_valid_d;
         bad_addr_q   <= bad_addr_d;
         obuf_q       <= obuf_d;
         obuf_valid_q <= obuf_valid_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign bus.mesh_ready_in  = mesh_ready_c;
   assign bus.node_valid_in  = node_valid_in_c;
   assign bus.node_in_pkt    = ibuf_q;
   assign bus.node_ready_out = grant ? win_onehot : '0;
   assign bus.mesh_valid_out = obuf_valid_q;
   assign bus.mesh_out_pkt   = obuf_q;
   assign bad_addr           = bad_addr_q;

endmodule : bank_arbiter

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter: ingress and egress vector tables plus
// hand-written sequences for misaddressing, concurrency, reset and DONE order.
module tb_bank_arbiter;
   import types::*;

   localparam int unsigned N = parameters::NODES_PER_BANK;

   logic clk = 1'b0;
   logic rst;
   logic bad_addr;
   int   n_cmp = 0;
   int   n_bad = 0;

   bank_arbiter_if #(.N_NODES(N)) bus ();

   bank_arbiter #(.N_NODES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .bad_addr (bad_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         mvi;
      pkt_t         mpkt;
      logic [N-1:0] nri;
      logic         e_mri;
      logic [N-1:0] e_nvi;
      pkt_t         e_nip;
   } ing_t;

   typedef struct {
      logic [N-1:0] nvo;
      int           tag;
      logic         mro;
      logic [N-1:0] e_nro;
      logic         e_mvo;
      pkt_t         e_mop;
   } egr_t;

   ing_t ing[$];
   egr_t egr[$];

   function automatic pkt_t mk_in(input int z, input int d, input ctrl_t c);
      pkt_t p;
      p.ctrl   = c;
      p.addr.x = COORD_W'(1);
      p.addr.y = COORD_W'(2);
      p.addr.z = COORD_W'(z);
      p.data   = DATA_W'(d);
      return p;
   endfunction

   function automatic pkt_t mk_out(input int node, input int tag, input ctrl_t c);
      pkt_t p;
      p.ctrl   = c;
      p.addr.x = COORD_W'(5);
      p.addr.y = COORD_W'(6);
      p.addr.z = COORD_W'(node);
      p.data   = DATA_W'((tag << 8) | node);
      return p;
   endfunction

   function automatic ing_t mk_ing(input logic mvi, input pkt_t mp, input logic [N-1:0] nri,
                                   input logic e_mri, input logic [N-1:0] e_nvi, input pkt_t e_nip);
      ing_t r;
      r.mvi = mvi; r.mpkt = mp; r.nri = nri;
      r.e_mri = e_mri; r.e_nvi = e_nvi; r.e_nip = e_nip;
      return r;
   endfunction

   function automatic egr_t mk_egr(input logic [N-1:0] nvo, input int tag, input logic mro,
                                   input logic [N-1:0] e_nro, input logic e_mvo, input pkt_t e_mop);
      egr_t r;
      r.nvo = nvo; r.tag = tag; r.mro = mro;
      r.e_nro = e_nro; r.e_mvo = e_mvo; r.e_mop = e_mop;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic mvi, input pkt_t mp, input logic [N-1:0] nri,
                        input logic [N-1:0] nvo, input int tag, input logic mro);
      bus.mesh_valid_in  = mvi;
      bus.mesh_in_pkt    = mp;
      bus.node_ready_in  = nri;
      bus.node_valid_out = nvo;
      bus.mesh_ready_out = mro;
      for (int i = 0; i < int'(N); i++) bus.node_out_pkt[i] = mk_out(i, tag, CTRL_SUM);
   endtask

   initial begin
      pkt_t a, b, c, d, e, f, g, first, second;
      logic [N-1:0] next_nvo;

      a = mk_in(2, 'h1234, CTRL_SUM);
      b = mk_in(2, 'h5678, CTRL_SUM);
      c = mk_in(0, 'h9ABC, CTRL_DONE);
      d = mk_in(3, 'hDEF0, CTRL_DATA);

      // mvi, pkt, nri | mri, nvi, nip
      ing.push_back(mk_ing(1'b0, '0, 4'b0000, 1'b1, 4'b0000, '0));
      ing.push_back(mk_ing(1'b1, a,  4'b0100, 1'b1, 4'b0000, '0));
      ing.push_back(mk_ing(1'b0, '0, 4'b0100, 1'b1, 4'b0100, a));
      ing.push_back(mk_ing(1'b1, b,  4'b0000, 1'b1, 4'b0000, '0));
      for (int i = 0; i < 5; i++)
         ing.push_back(mk_ing(1'b1, c, 4'b0000, 1'b0, 4'b0100, b));
      ing.push_back(mk_ing(1'b1, c,  4'b0100, 1'b1, 4'b0100, b));
      ing.push_back(mk_ing(1'b1, d,  4'b0001, 1'b1, 4'b0001, c));
      ing.push_back(mk_ing(1'b0, '0, 4'b0111, 1'b0, 4'b1000, d));
      ing.push_back(mk_ing(1'b0, '0, 4'b1000, 1'b1, 4'b1000, d));
      ing.push_back(mk_ing(1'b0, '0, 4'b0000, 1'b1, 4'b0000, '0));

      // nvo, tag, mro | nro, mvo, mop
      egr.push_back(mk_egr(4'b1011,  1, 1'b1, 4'b0001, 1'b0, '0));
      egr.push_back(mk_egr(4'b1011,  2, 1'b1, 4'b0010, 1'b1, mk_out(0, 1, CTRL_SUM)));
      egr.push_back(mk_egr(4'b1011,  3, 1'b1, 4'b1000, 1'b1, mk_out(1, 2, CTRL_SUM)));
      egr.push_back(mk_egr(4'b1011,  4, 1'b1, 4'b0001, 1'b1, mk_out(3, 3, CTRL_SUM)));
      egr.push_back(mk_egr(4'b1011,  5, 1'b1, 4'b0010, 1'b1, mk_out(0, 4, CTRL_SUM)));
      egr.push_back(mk_egr(4'b1011,  6, 1'b1, 4'b1000, 1'b1, mk_out(1, 5, CTRL_SUM)));
      for (int i = 0; i < 3; i++)
         egr.push_back(mk_egr(4'b1011, 7, 1'b0, 4'b0000, 1'b1, mk_out(3, 6, CTRL_SUM)));
      egr.push_back(mk_egr(4'b1011,  8, 1'b1, 4'b0001, 1'b1, mk_out(3, 6, CTRL_SUM)));
      egr.push_back(mk_egr(4'b0000,  9, 1'b1, 4'b0000, 1'b1, mk_out(0, 8, CTRL_SUM)));
      egr.push_back(mk_egr(4'b0000,  9, 1'b1, 4'b0000, 1'b0, '0));
      egr.push_back(mk_egr(4'b1001, 10, 1'b0, 4'b1000, 1'b0, '0));
      egr.push_back(mk_egr(4'b1001, 11, 1'b0, 4'b0000, 1'b1, mk_out(3, 10, CTRL_SUM)));
      egr.push_back(mk_egr(4'b1001, 12, 1'b1, 4'b0001, 1'b1, mk_out(3, 10, CTRL_SUM)));
      egr.push_back(mk_egr(4'b0000, 13, 1'b1, 4'b0000, 1'b1, mk_out(0, 12, CTRL_SUM)));
      egr.push_back(mk_egr(4'b0000, 13, 1'b0, 4'b0000, 1'b0, '0));

      // reset state
      rst = 1'b1;
      drive(1'b0, '0, '0, '0, 0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mri", 32'(bus.mesh_ready_in), 32'(1'b1));
      chk("rst_nvi", 32'(bus.node_valid_in), 32'(0));
      chk("rst_nro", 32'(bus.node_ready_out), 32'(0));
      chk("rst_mvo", 32'(bus.mesh_valid_out), 32'(0));
      chk("rst_nip", 32'(bus.node_in_pkt), 32'(0));
      chk("rst_mop", 32'(bus.mesh_out_pkt), 32'(0));
      chk("rst_bad", 32'(bad_addr), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      // ingress table
      for (int v = 0; v < ing.size(); v++) begin
         drive(ing[v].mvi, ing[v].mpkt, ing[v].nri, '0, 0, 1'b0);
         #1;
         chk($sformatf("ing%0d_mri", v), 32'(bus.mesh_ready_in), 32'(ing[v].e_mri));
         chk($sformatf("ing%0d_nvi", v), 32'(bus.node_valid_in), 32'(ing[v].e_nvi));
         if (ing[v].e_nvi != '0)
            chk($sformatf("ing%0d_nip", v), 32'(bus.node_in_pkt), 32'(ing[v].e_nip));
         @(negedge clk);
      end

      // egress table
      for (int v = 0; v < egr.size(); v++) begin
         drive(1'b0, '0, '0, egr[v].nvo, egr[v].tag, egr[v].mro);
         #1;
         chk($sformatf("egr%0d_nro", v), 32'(bus.node_ready_out), 32'(egr[v].e_nro));
         chk($sformatf("egr%0d_mvo", v), 32'(bus.mesh_valid_out), 32'(egr[v].e_mvo));
         if (egr[v].e_mvo)
            chk($sformatf("egr%0d_mop", v), 32'(bus.mesh_out_pkt), 32'(egr[v].e_mop));
         @(negedge clk);
      end

      // misaddressed ingress: z == N
      drive(1'b1, mk_in(int'(N), 'h0BAD, CTRL_SUM), '1, '0, 0, 1'b0);
      #1;
      chk("bad_acc_mri", 32'(bus.mesh_ready_in), 32'(1'b1));
      chk("bad_pre", 32'(bad_addr), 32'(0));
      @(negedge clk);
      drive(1'b0, '0, '1, '0, 0, 1'b0);
      #1;
      chk("bad_nvi", 32'(bus.node_valid_in), 32'(0));
      chk("bad_mri", 32'(bus.mesh_ready_in), 32'(1'b1));
      @(negedge clk);
      drive(1'b1, mk_in(1, 'h0111, CTRL_SUM), 4'b0010, '0, 0, 1'b0);
      #1;
      chk("bad_set", 32'(bad_addr), 32'(1'b1));
      chk("bad_nvi_idle", 32'(bus.node_valid_in), 32'(0));
      @(negedge clk);
      drive(1'b0, '0, 4'b0010, '0, 0, 1'b0);
      #1;
      chk("bad_next_nvi", 32'(bus.node_valid_in), 32'(4'b0010));
      chk("bad_next_nip", 32'(bus.node_in_pkt), 32'(mk_in(1, 'h0111, CTRL_SUM)));
      chk("bad_sticky1", 32'(bad_addr), 32'(1'b1));
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 0, 1'b0);
      #1;
      chk("bad_sticky2", 32'(bad_addr), 32'(1'b1));
      @(negedge clk);

      // ingress accept, ingress drain, egress grant and mesh drain together
      e = mk_in(1, 'hAAAA, CTRL_SUM);
      f = mk_in(3, 'hBBBB, CTRL_DATA);
      drive(1'b1, e, 4'b0000, 4'b0100, 20, 1'b0);
      #1;
      chk("sim1_mri", 32'(bus.mesh_ready_in), 32'(1'b1));
      chk("sim1_nro", 32'(bus.node_ready_out), 32'(4'b0100));
      @(negedge clk);
      drive(1'b1, f, 4'b0010, 4'b0001, 21, 1'b1);
      #1;
      chk("sim2_nvi", 32'(bus.node_valid_in), 32'(4'b0010));
      chk("sim2_nip", 32'(bus.node_in_pkt), 32'(e));
      chk("sim2_mri", 32'(bus.mesh_ready_in), 32'(1'b1));
      chk("sim2_mvo", 32'(bus.mesh_valid_out), 32'(1'b1));
      chk("sim2_mop", 32'(bus.mesh_out_pkt), 32'(mk_out(2, 20, CTRL_SUM)));
      chk("sim2_nro", 32'(bus.node_ready_out), 32'(4'b0001));
      @(negedge clk);
      drive(1'b0, '0, 4'b1000, '0, 0, 1'b0);
      #1;
      chk("sim3_nvi", 32'(bus.node_valid_in), 32'(4'b1000));
      chk("sim3_nip", 32'(bus.node_in_pkt), 32'(f));
      chk("sim3_mop", 32'(bus.mesh_out_pkt), 32'(mk_out(0, 21, CTRL_SUM)));
      @(negedge clk);

      // reset with both buffers occupied
      g = mk_in(2, 'hCCCC, CTRL_SUM);
      drive(1'b1, g, 4'b0000, '0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, '0, 4'b0000, 4'b1111, 22, 1'b0);
      #1;
      chk("pre_rst_nvi", 32'(bus.node_valid_in), 32'(4'b0100));
      chk("pre_rst_mvo", 32'(bus.mesh_valid_out), 32'(1'b1));
      @(negedge clk);
      #1;
      chk("mid_rst_mri", 32'(bus.mesh_ready_in), 32'(1'b1));
      chk("mid_rst_nvi", 32'(bus.node_valid_in), 32'(0));
      chk("mid_rst_nro", 32'(bus.node_ready_out), 32'(0));
      chk("mid_rst_mvo", 32'(bus.mesh_valid_out), 32'(0));
      chk("mid_rst_nip", 32'(bus.node_in_pkt), 32'(0));
      chk("mid_rst_mop", 32'(bus.mesh_out_pkt), 32'(0));
      chk("mid_rst_bad", 32'(bad_addr), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, '0, '1, '0, 0, 1'b1);
      #1;
      chk("post_rst_nvi", 32'(bus.node_valid_in), 32'(0));
      chk("post_rst_mvo", 32'(bus.mesh_valid_out), 32'(0));
      @(negedge clk);
      drive(1'b0, '0, '0, 4'b1111, 30, 1'b1);
      #1;
      chk("post_rst_ptr", 32'(bus.node_ready_out), 32'(4'b0001));
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 0, 1'b1);
      #1;
      chk("post_rst_mop", 32'(bus.mesh_out_pkt), 32'(mk_out(0, 30, CTRL_SUM)));
      @(negedge clk);

      // DONE handling from rr_ptr == 0
      rst = 1'b1;
      drive(1'b0, '0, '0, '0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, '0, '0, 4'b1001, 40, 1'b1);
      bus.node_out_pkt[3] = mk_out(3, 40, CTRL_DONE);
      #1;
`ifdef BANK_ARB_DONE_PRIORITY_EN
      chk("done_first", 32'(bus.node_ready_out), 32'(4'b1000));
      first    = mk_out(3, 40, CTRL_DONE);
      second   = mk_out(0, 40, CTRL_SUM);
      next_nvo = 4'b0001;
`else
      chk("done_first", 32'(bus.node_ready_out), 32'(4'b0001));
      first    = mk_out(0, 40, CTRL_SUM);
      second   = mk_out(3, 40, CTRL_DONE);
      next_nvo = 4'b1000;
`endif
      @(negedge clk);
      drive(1'b0, '0, '0, next_nvo, 40, 1'b1);
      bus.node_out_pkt[3] = mk_out(3, 40, CTRL_DONE);
      #1;
      chk("done_second", 32'(bus.node_ready_out), 32'(next_nvo));
      chk("done_mop1", 32'(bus.mesh_out_pkt), 32'(first));
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 0, 1'b1);
      #1;
      chk("done_mvo2", 32'(bus.mesh_valid_out), 32'(1'b1));
      chk("done_mop2", 32'(bus.mesh_out_pkt), 32'(second));
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 0, 1'b0);
      #1;
      chk("done_empty", 32'(bus.mesh_valid_out), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bank_arbiter
